// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM states, parity modes
// and the bit-period helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Clock cycles per bit, truncated.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Character-input handshake of the buffered UART transmitter (valid/ready).
interface uart_tx_buffered_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead character FIFO; pointers carry an extra wrap bit so
// full and empty are distinguishable without a separate counter.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign level   = LW'(wr_ptr_q - rd_ptr_q);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter with back-to-back framing.
// Define UART_TX_PARITY_EN to build in the parity bit state and logic.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  uart_tx_buffered_if.slave               in_if,
  output logic                            uart_tx,
  output logic                            busy,
  output logic                            tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = 4;

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 uart_tx_q, uart_tx_d;
  logic                 tx_done_q, tx_done_d;
  logic                 baud_tick;
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd_data;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (in_if.in_valid),
    .wr_data (in_if.in_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ACTIVE = (PARITY != PAR_NONE);
  logic par_q, par_d, par_calc;

  // Parity is captured with the character so it is ready when the PARITY state arrives.
  assign par_calc = (PARITY == PAR_ODD) ? ~(^fifo_rd_data) : ^fifo_rd_data;

  always_comb begin
    par_d = fifo_pop ? par_calc : par_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) par_q <= 1'b0;
    else          par_q <= par_d;
  end
`else
  localparam bit PAR_ACTIVE = 1'b0 && (PARITY != PAR_NONE);
`endif

  assign baud_tick     = (cnt_q == CW'(DIV - 1));
  assign in_if.in_ready = !fifo_full;
  assign busy          = (state_q != ST_IDLE);
  assign uart_tx       = uart_tx_q;
  assign tx_done       = tx_done_q;

  // Line level is registered from the current state, so the line trails the FSM by one cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (state_q == ST_IDLE || baud_tick) ? '0 : cnt_q + CW'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    tx_done_d = 1'b0;
    uart_tx_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rd_data;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        uart_tx_d = 1'b0;
        if (baud_tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        uart_tx_d = shift_q[0];
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = PAR_ACTIVE ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        uart_tx_d = par_q;
        if (baud_tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (baud_tick) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            tx_done_d = 1'b1;
            bit_d     = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_rd_data;
              state_d  = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      uart_tx_q <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      uart_tx_q <= uart_tx_d;
      tx_done_q <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: two configurations driven with directed and random
// pushes, checked every cycle against a frame-timeline model of the line.
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int DEPTH    = 4;
  localparam int LW       = $clog2(DEPTH + 1);
  localparam int NDUT     = 2;
  localparam int MAXF     = 256;
  localparam int DB_A = 8, SB_A = 1, PM_A = PAR_EVEN;
  localparam int DB_B = 5, SB_B = 2, PM_B = PAR_ODD;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_buffered_if #(.DATA_BITS(DB_A)) if_a ();
  uart_tx_buffered_if #(.DATA_BITS(DB_B)) if_b ();
  logic tx_a, busy_a, done_a, tx_b, busy_b, done_b;
  logic [LW-1:0] lvl_a, lvl_b;

  uart_tx_buffered #(
    .CLK_FREQ (CLK_FREQ), .BAUD (BAUD), .DATA_BITS (DB_A),
    .STOP_BITS (SB_A), .PARITY (PM_A), .FIFO_DEPTH (DEPTH)
  ) dut_a (
    .clk (clk), .reset_n (reset_n), .in_if (if_a.slave),
    .uart_tx (tx_a), .busy (busy_a), .tx_done (done_a), .fifo_level (lvl_a)
  );

  uart_tx_buffered #(
    .CLK_FREQ (CLK_FREQ), .BAUD (BAUD), .DATA_BITS (DB_B),
    .STOP_BITS (SB_B), .PARITY (PM_B), .FIFO_DEPTH (DEPTH)
  ) dut_b (
    .clk (clk), .reset_n (reset_n), .in_if (if_b.slave),
    .uart_tx (tx_b), .busy (busy_b), .tx_done (done_b), .fifo_level (lvl_b)
  );

  // Model: one entry per accepted character: push edge, edge after which its start bit is on the line, data.
  int         fr_push  [NDUT][MAXF];
  int         fr_start [NDUT][MAXF];
  logic [8:0] fr_data  [NDUT][MAXF];
  int         nfr      [NDUT];
  int         last_s   [NDUT];
  int         acc      [NDUT];
  bit         vreq     [NDUT];
  logic [8:0] dreq     [NDUT];
  int         edge_n = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int db(input int i); return (i == 0) ? DB_A : DB_B; endfunction
  function automatic int sb(input int i); return (i == 0) ? SB_A : SB_B; endfunction
  function automatic int pm(input int i); return (i == 0) ? PM_A : PM_B; endfunction
  function automatic bit par_on(input int i); return PAR_BUILD && (pm(i) != PAR_NONE); endfunction
  function automatic int flen(input int i);
    return (1 + db(i) + (par_on(i) ? 1 : 0) + sb(i)) * DIV;
  endfunction

  function automatic logic exp_line(input int i, input int t);
    logic [8:0] d;
    int k;
    for (int n = 0; n < nfr[i]; n++) begin
      if (t >= fr_start[i][n] && t < fr_start[i][n] + flen(i)) begin
        d = fr_data[i][n];
        k = (t - fr_start[i][n]) / DIV;
        if (k == 0) return 1'b0;
        if (k <= db(i)) return d[k-1];
        if (par_on(i) && k == db(i) + 1) return (pm(i) == PAR_ODD) ? ~(^d) : ^d;
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int i, input int t);
    for (int n = 0; n < nfr[i]; n++)
      if (t >= fr_start[i][n] - 1 && t <= fr_start[i][n] + flen(i) - 2) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_done(input int i, input int t);
    for (int n = 0; n < nfr[i]; n++)
      if (t == fr_start[i][n] + flen(i) - 1) return 1'b1;
    return 1'b0;
  endfunction

  // Queued = pushed so far minus popped so far; a character leaves the FIFO the edge before its start bit.
  function automatic int exp_level(input int i, input int t);
    int lv = 0;
    for (int n = 0; n < nfr[i]; n++) begin
      if (fr_push[i][n] <= t) lv++;
      if (fr_start[i][n] - 1 <= t) lv--;
    end
    return lv;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      nfr[i]    = 0;
      last_s[i] = -1000000;
    end
  endtask

  task automatic check_dut(input int i, input int t);
    logic tx, bz, dn, rdy;
    logic [LW-1:0] lv;
    if (i == 0) begin tx = tx_a; bz = busy_a; dn = done_a; rdy = if_a.in_ready; lv = lvl_a; end
    else        begin tx = tx_b; bz = busy_b; dn = done_b; rdy = if_b.in_ready; lv = lvl_b; end
    check_eq($sformatf("uart_tx[%0d]@%0d", i, t), 32'(tx), 32'(exp_line(i, t)));
    check_eq($sformatf("busy[%0d]@%0d", i, t), 32'(bz), 32'(exp_busy(i, t)));
    check_eq($sformatf("tx_done[%0d]@%0d", i, t), 32'(dn), 32'(exp_done(i, t)));
    check_eq($sformatf("fifo_level[%0d]@%0d", i, t), 32'(lv), 32'(exp_level(i, t)));
    check_eq($sformatf("in_ready[%0d]@%0d", i, t), 32'(rdy), 32'(exp_level(i, t) < DEPTH));
  endtask

  // Drive the request for edge e and enter it in the model if the model says it is accepted.
  task automatic drive(input int i, input int e);
    logic rdy;
    logic [8:0] d;
    int s;
    if (nfr[i] >= MAXF) vreq[i] = 1'b0;
    d   = dreq[i] & 9'((1 << db(i)) - 1);
    rdy = (i == 0) ? if_a.in_ready : if_b.in_ready;
    if (vreq[i] && rdy) acc[i]++;
    if (i == 0) begin if_a.in_valid = vreq[0]; if_a.in_data = d[DB_A-1:0]; end
    else        begin if_b.in_valid = vreq[1]; if_b.in_data = d[DB_B-1:0]; end
    if (vreq[i] && exp_level(i, e - 1) < DEPTH) begin
      s = (e + 2 > last_s[i] + flen(i)) ? e + 2 : last_s[i] + flen(i);
      fr_push[i][nfr[i]]  = e;
      fr_start[i][nfr[i]] = s;
      fr_data[i][nfr[i]]  = d;
      nfr[i]++;
      last_s[i] = s;
      $display("push dut%0d edge %0d data 0x%02h start-bit edge %0d", i, e, d, s);
    end
  endtask

  task automatic cycle();
    int t;
    @(negedge clk);
    t = edge_n;
    for (int i = 0; i < NDUT; i++) check_dut(i, t);
    for (int i = 0; i < NDUT; i++) drive(i, t + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < NDUT; i++) vreq[i] = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic push_both(input logic [8:0] d);
    for (int i = 0; i < NDUT; i++) begin vreq[i] = 1'b1; dreq[i] = d; end
    cycle();
    for (int i = 0; i < NDUT; i++) vreq[i] = 1'b0;
  endtask

  initial begin
    int s_first;
    int j;
    model_reset();
    for (int i = 0; i < NDUT; i++) begin vreq[i] = 1'b0; dreq[i] = '0; acc[i] = 0; end
    if_a.in_valid = 1'b0; if_a.in_data = '0;
    if_b.in_valid = 1'b0; if_b.in_data = '0;

    reset_n = 1'b0;
    repeat (3) cycle();
    reset_n = 1'b1;

    // Single frame, then two back-to-back characters.
    push_both(9'h0A5);
    idle(130);
    push_both(9'h000);
    push_both(9'h0FF);
    idle(260);

    // Hold valid for 8 cycles into an empty FIFO of depth 4.
    for (int i = 0; i < NDUT; i++) acc[i] = 0;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NDUT; i++) begin vreq[i] = 1'b1; dreq[i] = 9'($urandom); end
      cycle();
    end
    check_eq("accepted[0]", 32'(acc[0]), 32'd5);
    check_eq("accepted[1]", 32'(acc[1]), 32'd5);
    idle(5 * flen(0) + 20);

    // Parity-bearing characters.
    push_both(9'h007);
    idle(130);

    // Reset during the fourth data bit, with a second character still queued.
    push_both(9'h0A5);
    s_first = last_s[0];
    push_both(9'h03C);
    j = 0;
    while (edge_n - s_first < 44 && j < 300) begin
      cycle();
      j++;
    end
    check_eq("reset_window", 32'(edge_n - s_first), 32'd44);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("async_rst uart_tx[0]", 32'(tx_a), 32'd1);
    check_eq("async_rst uart_tx[1]", 32'(tx_b), 32'd1);
    check_eq("async_rst busy[0]", 32'(busy_a), 32'd0);
    check_eq("async_rst busy[1]", 32'(busy_b), 32'd0);
    check_eq("async_rst level[0]", 32'(lvl_a), 32'd0);
    check_eq("async_rst level[1]", 32'(lvl_b), 32'd0);
    repeat (3) cycle();
    reset_n = 1'b1;
    idle(60);

    // Random traffic, light then heavy.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NDUT; i++) begin
        vreq[i] = ($urandom_range(0, 99) < ((c < 1500) ? 3 : 9));
        dreq[i] = 9'($urandom);
      end
      cycle();
    end

    // Drain, bounded.
    for (int i = 0; i < NDUT; i++) vreq[i] = 1'b0;
    j = 0;
    while ((edge_n <= last_s[0] + flen(0) + 2 || edge_n <= last_s[1] + flen(1) + 2) && j < 3000) begin
      cycle();
      j++;
    end
    check_eq("drain_busy[0]", 32'(busy_a), 32'd0);
    check_eq("drain_busy[1]", 32'(busy_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
